// File: rtl/forward_neuron_mac.sv
// Forward-pass neuron engine: out = ReLU(sum(w_i*a_i) + bias), signed Q8.8.
// Weights and bias are fetched over the MMU read port; activations arrive as a valid/ready stream.
module forward_neuron_mac #(
    parameter int unsigned N_MAX        = 16,
    parameter logic [15:0] WEIGHTS_BASE = 16'h0100,
    parameter logic [15:0] BIASES_BASE  = 16'h0200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [4:0]  neuron_id,
    input  logic [4:0]  num_inputs,
    input  logic [15:0] act_i,
    input  logic        act_valid_i,
    output logic        act_ready_o,
    output logic [31:0] mmu_adr_o,
    output logic        mmu_req_o,
    output logic        mmu_we_o,
    input  logic [31:0] mmu_dat_i,
    input  logic        mmu_ack_i,
    output logic [31:0] out,
    output logic [15:0] derivative,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic        busy_o
);

    localparam int unsigned DW    = 16;
    localparam int unsigned PW    = 32;
    localparam int unsigned ACC_W = 40;
    localparam int unsigned IDX_W = 5;

    typedef enum logic [2:0] {
        S_IDLE, S_W_REQ, S_A_WAIT, S_MAC, S_B_REQ, S_ACT, S_DONE
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic        [IDX_W-1:0]   r_nid;
    logic        [IDX_W-1:0]   r_num;
    logic        [IDX_W-1:0]   r_idx;
    logic signed [DW-1:0]      r_w;
    logic signed [DW-1:0]      r_a;
    logic signed [DW-1:0]      r_b;
    logic signed [ACC_W-1:0]   r_acc;
    logic        [31:0]        r_out;
    logic        [DW-1:0]      r_deriv;

    logic        [IDX_W-1:0]   w_num_clamped;
    logic        [DW-1:0]      w_w_adr;
    logic        [DW-1:0]      w_b_adr;
    logic signed [PW-1:0]      w_prod;
    logic signed [ACC_W-1:0]   w_shift;
    logic signed [ACC_W:0]     w_z_wide;
    logic signed [DW-1:0]      w_z;
    logic                      w_pos;
    logic                      w_unused;

    assign w_num_clamped = (num_inputs > IDX_W'(N_MAX)) ? IDX_W'(N_MAX) : num_inputs;
    assign w_w_adr       = WEIGHTS_BASE + {7'd0, r_nid, 4'd0} + DW'(r_idx);
    assign w_b_adr       = BIASES_BASE + DW'(r_nid);
    assign w_prod        = r_w * r_a;
    assign w_shift       = r_acc >>> 8;
    assign w_z_wide      = (ACC_W+1)'(w_shift) + (ACC_W+1)'(r_b);
    assign w_z           = (w_z_wide > 41'sd32767)  ? 16'sh7FFF :
                           (w_z_wide < -41'sd32768) ? 16'sh8000 : w_z_wide[DW-1:0];
    assign w_pos         = !w_z[DW-1] && (w_z != '0);
    assign w_unused      = ^mmu_dat_i[31:16];

    assign mmu_we_o   = 1'b0;
    assign out        = r_out;
    assign derivative = r_deriv;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = (w_num_clamped == '0) ? S_B_REQ : S_W_REQ;
            S_W_REQ:  if (mmu_ack_i) w_state_nxt = S_A_WAIT;
            S_A_WAIT: if (act_valid_i) w_state_nxt = S_MAC;
            S_MAC:    w_state_nxt = (r_idx + 5'd1 == r_num) ? S_B_REQ : S_W_REQ;
            S_B_REQ:  if (mmu_ack_i) w_state_nxt = S_ACT;
            S_ACT:    w_state_nxt = S_DONE;
            S_DONE:   if (out_ready_i) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the state register only
    always_comb begin
        act_ready_o = 1'b0;
        mmu_req_o   = 1'b0;
        mmu_adr_o   = '0;
        out_valid_o = 1'b0;
        busy_o      = 1'b1;
        case (r_state)
            S_IDLE:   busy_o = 1'b0;
            S_W_REQ:  begin mmu_req_o = 1'b1; mmu_adr_o = 32'(w_w_adr); end
            S_A_WAIT: act_ready_o = 1'b1;
            S_B_REQ:  begin mmu_req_o = 1'b1; mmu_adr_o = 32'(w_b_adr); end
            S_DONE:   out_valid_o = 1'b1;
            default:  ;
        endcase
    end

    // Datapath: operand capture, accumulate, bias + ReLU
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nid   <= '0;
            r_num   <= '0;
            r_idx   <= '0;
            r_w     <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_out   <= '0;
            r_deriv <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_nid <= neuron_id;
                    r_num <= w_num_clamped;
                    r_acc <= '0;
                    r_idx <= '0;
                end
                S_W_REQ:  if (mmu_ack_i) r_w <= mmu_dat_i[DW-1:0];
                S_A_WAIT: if (act_valid_i) r_a <= act_i;
                S_MAC: begin
                    r_acc <= r_acc + ACC_W'(w_prod);
                    r_idx <= r_idx + 5'd1;
                end
                S_B_REQ:  if (mmu_ack_i) r_b <= mmu_dat_i[DW-1:0];
                S_ACT: begin
                    r_out   <= w_pos ? 32'(w_z) : 32'd0;
                    r_deriv <= w_pos ? 16'h0100 : 16'h0000;
                end
                default: ;
            endcase
        end
    end

endmodule
